// File: rtl/bram2_port_arbiter_if.sv
// Bundle of both requester channels and the shared BRAM port for bram2_port_arbiter.
// slave = arbiter side, master = requester/BRAM side.
interface bram2_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4
);
  // Handshakes: a request transfers in a cycle with req_valid=1 and req_ready=1;
  // a response pops in a cycle with rsp_valid=1 and rsp_ready=1. Payloads hold while valid=1.
  logic                  r0_req_valid;
  logic                  r0_req_ready;
  logic [ADDR_WIDTH-1:0] r0_req_addr;
  logic [WE_WIDTH-1:0]   r0_req_we;
  logic [DATA_WIDTH-1:0] r0_req_wdata;
  logic                  r0_rsp_valid;
  logic                  r0_rsp_ready;
  logic [DATA_WIDTH-1:0] r0_rsp_data;

  logic                  r1_req_valid;
  logic                  r1_req_ready;
  logic [ADDR_WIDTH-1:0] r1_req_addr;
  logic [WE_WIDTH-1:0]   r1_req_we;
  logic [DATA_WIDTH-1:0] r1_req_wdata;
  logic                  r1_rsp_valid;
  logic                  r1_rsp_ready;
  logic [DATA_WIDTH-1:0] r1_rsp_data;

  logic                  bram_en;
  logic [WE_WIDTH-1:0]   bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_wdata;
  logic [DATA_WIDTH-1:0] bram_rdata;

  modport slave (
    input  r0_req_valid, r0_req_addr, r0_req_we, r0_req_wdata, r0_rsp_ready,
    input  r1_req_valid, r1_req_addr, r1_req_we, r1_req_wdata, r1_rsp_ready,
    input  bram_rdata,
    output r0_req_ready, r0_rsp_valid, r0_rsp_data,
    output r1_req_ready, r1_rsp_valid, r1_rsp_data,
    output bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output r0_req_valid, r0_req_addr, r0_req_we, r0_req_wdata, r0_rsp_ready,
    output r1_req_valid, r1_req_addr, r1_req_we, r1_req_wdata, r1_rsp_ready,
    output bram_rdata,
    input  r0_req_ready, r0_rsp_valid, r0_rsp_data,
    input  r1_req_ready, r1_rsp_valid, r1_rsp_data,
    input  bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/bram2_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with credit-checked FWFT response FIFOs.
// Optional statistics counters are enabled by defining BRAM_ARB_STATS_EN.
module bram2_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4,
  parameter int PIPELINED  = 0,
  parameter int RSP_DEPTH  = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic CLK,
  input  logic RST,
  bram2_port_arbiter_if.slave bus
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_grant0,
  output logic [CNT_WIDTH-1:0] stat_grant1,
  output logic [CNT_WIDTH-1:0] stat_conflict
`endif
);
  localparam int              L        = 1 + PIPELINED;
  localparam int              PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [3:0]      DEPTH_C  = 4'(RSP_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(RSP_DEPTH - 1);

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
  end

  logic [1:0]            req_valid, rsp_ready, elig, gnt, push, pop, store, take, rsp_valid;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [WE_WIDTH-1:0]   req_we    [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [DATA_WIDTH-1:0] rsp_data  [2];
  logic                  lp, gid;
  logic                  pipe_v  [L];
  logic                  pipe_id [L];
  logic [3:0]            occ  [2];
  logic [3:0]            infl [2];
  logic [PW-1:0]         rd_ptr [2];
  logic [PW-1:0]         wr_ptr [2];
  logic [DATA_WIDTH-1:0] mem [2][2**PW];

  assign req_valid    = {bus.r1_req_valid, bus.r0_req_valid};
  assign rsp_ready    = {bus.r1_rsp_ready, bus.r0_rsp_ready};
  assign req_addr[0]  = bus.r0_req_addr;
  assign req_addr[1]  = bus.r1_req_addr;
  assign req_we[0]    = bus.r0_req_we;
  assign req_we[1]    = bus.r1_req_we;
  assign req_wdata[0] = bus.r0_req_wdata;
  assign req_wdata[1] = bus.r1_req_wdata;

  // Credits: FIFO entries plus results still in the pipe must stay within RSP_DEPTH.
  always_comb begin
    infl[0] = '0;
    infl[1] = '0;
    for (int i = 0; i < L; i++)
      if (pipe_v[i]) infl[pipe_id[i]] = infl[pipe_id[i]] + 4'd1;
  end

  always_comb begin
    for (int x = 0; x < 2; x++)
      elig[x] = req_valid[x] && ((occ[x] + infl[x]) < DEPTH_C);
    gnt = '0;
    gid = 1'b0;
    if (!RST && (elig != 2'b00)) begin
      gid      = (elig == 2'b11) ? ~lp : elig[1];
      gnt[gid] = 1'b1;
    end
  end

  assign bus.r0_req_ready = gnt[0];
  assign bus.r1_req_ready = gnt[1];
  assign bus.bram_en      = |gnt;
  assign bus.bram_we      = (|gnt) ? req_we[gid]    : '0;
  assign bus.bram_addr    = (|gnt) ? req_addr[gid]  : '0;
  assign bus.bram_wdata   = (|gnt) ? req_wdata[gid] : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lp <= 1'b1;
      for (int i = 0; i < L; i++) begin
        pipe_v[i]  <= 1'b0;
        pipe_id[i] <= 1'b0;
      end
    end else begin
      pipe_v[0]  <= |gnt;
      pipe_id[0] <= gid;
      for (int i = 1; i < L; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
      if (|gnt) lp <= gid;
    end
  end

  // An empty FIFO forwards the arriving word directly so the response appears L cycles after the grant.
  always_comb begin
    for (int x = 0; x < 2; x++) begin
      push[x]      = pipe_v[L-1] && (pipe_id[L-1] == 1'(x));
      rsp_valid[x] = !RST && ((occ[x] != 4'd0) || push[x]);
      if (RST)                rsp_data[x] = '0;
      else if (occ[x] != 4'd0) rsp_data[x] = mem[x][rd_ptr[x]];
      else if (push[x])       rsp_data[x] = bus.bram_rdata;
      else                    rsp_data[x] = '0;
      pop[x]   = rsp_valid[x] && rsp_ready[x];
      store[x] = push[x] && !(pop[x] && (occ[x] == 4'd0));
      take[x]  = pop[x] && (occ[x] != 4'd0);
    end
  end

  always_ff @(posedge CLK) begin
    for (int x = 0; x < 2; x++) begin
      if (RST) begin
        occ[x]    <= '0;
        rd_ptr[x] <= '0;
        wr_ptr[x] <= '0;
      end else begin
        if (store[x]) begin
          mem[x][wr_ptr[x]] <= bus.bram_rdata;
          wr_ptr[x]         <= (wr_ptr[x] == LAST_PTR) ? '0 : wr_ptr[x] + 1'b1;
        end
        if (take[x])
          rd_ptr[x] <= (rd_ptr[x] == LAST_PTR) ? '0 : rd_ptr[x] + 1'b1;
        occ[x] <= occ[x] + {3'b000, store[x]} - {3'b000, take[x]};
      end
    end
  end

  assign bus.r0_rsp_valid = rsp_valid[0];
  assign bus.r1_rsp_valid = rsp_valid[1];
  assign bus.r0_rsp_data  = rsp_data[0];
  assign bus.r1_rsp_data  = rsp_data[1];

`ifdef BRAM_ARB_STATS_EN
  // Conflict counts raw simultaneous requests, whether or not both were eligible.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt[0])             stat_grant0   <= stat_grant0 + 1'b1;
      if (gnt[1])             stat_grant1   <= stat_grant1 + 1'b1;
      if (req_valid == 2'b11) stat_conflict <= stat_conflict + 1'b1;
    end
  end
`endif
endmodule
